io_port_responder: RTL
======================

# io_port_responder

Memory-mapped I/O responder on the processor's data-memory bus. It decodes a 16-byte window at `IO_BASE` and serves processor loads and stores from the same address/strobe signals that drive the data RAM. It drives the `PortOut` register and synchronizes `PortIn`. It tracks changes on `PortIn` with a sticky flag and a saturating event counter. The top level uses `IOSelect` to choose between `ReadData` and the RAM read data.

## Interface
- `DATA_WIDTH`, 32, bus data width
- `IO_BASE`, 32'h1001_0100, byte base address of the window; bits [3:0] must be zero
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `Address`  in  32  byte address from the ALU result
- `WriteData`  in  DATA_WIDTH  store data (rt)
- `MemWrite`  in  1  store strobe
- `MemRead`  in  1  load strobe
- `ReadData`  out  DATA_WIDTH  load data; combinational
- `IOSelect`  out  1  high when `Address[31:4] == IO_BASE[31:4]`; combinational
- `PortIn`  in  8  asynchronous external input
- `PortOut`  out  32  output port register
- `PortOutStrobe`  out  1  one-cycle pulse after each `PORT_OUT` write

## Operation
- Register decode uses `Address[3:2]`. `Address[1:0]` is ignored. There are no byte or halfword lanes.
  - 0x0 `PORT_OUT` (RW): a store latches `WriteData`; a load returns `PortOut`.
  - 0x4 `PORT_IN` (RO): returns `{24'b0, sync2}`. A load clears `CHANGED`. Stores are ignored.
  - 0x8 `STATUS` (RO): bit0 = `CHANGED`, bits[15:8] = `CHG_COUNT`, all other bits 0. Stores are ignored.
  - 0xC `CLEAR` (WO): any store clears both `CHANGED` and `CHG_COUNT`. A load returns 0.
- Out-of-window accesses: `IOSelect`=0, `ReadData`=0, no state change. Read-clear also requires `IOSelect`.
- `ReadData` is 0 whenever `MemRead`=0.
- Input path: `sync1` <= `PortIn`; `sync2` <= `sync1`; `prev` <= `sync2`. `chg = (sync2 != prev)`.
- Event logic, per edge, in priority order:
  - Clear: a load of `PORT_IN` clears `CHANGED` only. A store to `CLEAR` clears both `CHANGED` and `CHG_COUNT`.
  - If `chg`: `CHANGED` is set to 1 and `CHG_COUNT` increments, applied after the clear. A `CLEAR` store coincident with `chg` therefore yields count=1 and flag=1. A `PORT_IN` load coincident with `chg` leaves the flag at 1.
  - `CHG_COUNT` saturates at 255 and does not wrap.
- If `MemWrite` and `MemRead` are both asserted, the load returns the pre-edge value and the store takes effect at the edge.
- `PortOutStrobe` <= (store to `PORT_OUT`). It pulses once per store cycle. Back-to-back stores hold it high on consecutive cycles.

## Timing
- Loads are combinational within the issuing cycle, which matches unicycle RAM read timing.
- Stores and read-clears take effect at the rising edge that ends the access cycle.
- `PortIn` latency:
  - A change sampled into `sync1` at edge k is readable in `PORT_IN` after edge k+1.
  - `CHANGED` and `CHG_COUNT` update at edge k+2.
- Glitches shorter than one clock may be missed. This is accepted.
- Reset (synchronous, at the edge with `reset`=1): `PortOut`, `sync1`, `sync2`, `prev`, `CHANGED`, `CHG_COUNT` and `PortOutStrobe` all go to 0.
  - Reset overrides any coincident store.
  - Because `prev` and `sync2` are both 0 after reset, a nonzero `PortIn` generates exactly one change event 2 edges after reset deasserts.
- The block has no stalls or wait states. A request is complete in one cycle.

## Structure
- Shared package `io_map_pkg` holds:
  - `IO_BASE`
  - register offsets `PORT_OUT_OFS`=4'h0, `PORT_IN_OFS`=4'h4, `STATUS_OFS`=4'h8, `CLEAR_OFS`=4'hC
  - `STATUS` bit positions `ST_CHANGED`=0, `ST_COUNT_LSB`=8
- One sub-module, `port_in_sync`: the 3-register chain (`sync1`/`sync2`/`prev`), with outputs `sync2` and `chg`.
- The rest of the block (decode, registers, counter and read mux) stays in `io_port_responder`.

## Test plan
- Reset, then store 0xDEADBEEF to `IO_BASE`+0 → `PortOut`=0xDEADBEEF after the edge; `PortOutStrobe` high for exactly 1 cycle; a load of +0 returns 0xDEADBEEF.
- `PortIn` 0x00→0x5A at edge k → `PORT_IN` reads 0x5A from cycle k+2; `STATUS` reads 0x0000_0101 after edge k+2; a load of +4 clears it, so `STATUS` reads 0x0000_0100.
- Toggle `PortIn` 300 times, each hold ≥2 cycles → `STATUS`[15:8]=0xFF (saturated); a store to +0xC → `STATUS`=0.
- Store to +0xC in the same cycle that `chg`=1 → `STATUS`=0x0000_0101.
- Store and load to `IO_BASE`+0x40 (outside the window) → `IOSelect`=0, `ReadData`=0, `PortOut` unchanged. Store to +0x5 (misaligned) → behaves as `PORT_IN`, so it is ignored.
- Assert `reset` coincident with a store of 0x1234 to +0 → `PortOut`=0 and no strobe. Then hold `PortIn`=0x80 through reset → exactly one change event, count=1.

Source files
------------

// File: rtl/io_map_pkg.sv
// Address map and status-word layout shared by the I/O responder and its users.
package io_map_pkg;

  localparam logic [31:0] IO_BASE = 32'h1001_0100;

  localparam logic [3:0] PORT_OUT_OFS = 4'h0;
  localparam logic [3:0] PORT_IN_OFS  = 4'h4;
  localparam logic [3:0] STATUS_OFS   = 4'h8;
  localparam logic [3:0] CLEAR_OFS    = 4'hC;

  localparam int ST_CHANGED   = 0;
  localparam int ST_COUNT_LSB = 8;
  localparam int COUNT_W      = 8;

  typedef enum logic [1:0] {
    REG_PORT_OUT = 2'd0,
    REG_PORT_IN  = 2'd1,
    REG_STATUS   = 2'd2,
    REG_CLEAR    = 2'd3
  } ioReg_e;

  // Word-granular decode: the low two byte-address bits never select anything.
  function automatic ioReg_e regOf(input logic [3:0] ofs);
    return ioReg_e'(ofs[3:2]);
  endfunction

endpackage

// File: rtl/port_in_sync.sv
// Two-flop synchronizer for the external input port plus a one-cycle history
// register used to detect changes on the synchronized value.
module port_in_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] PortIn,
  output logic [7:0] sync2,
  output logic       chg
);

  logic [7:0] sync1;
  logic [7:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign chg = (sync2 != prev);

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O window on the data-memory bus: output port register,
// synchronized input port, and a sticky change flag with a saturating counter.
module io_port_responder #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = io_map_pkg::IO_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  IOSelect,
  input  logic [7:0]            PortIn,
  output logic [31:0]           PortOut,
  output logic                  PortOutStrobe
);

  import io_map_pkg::*;

  // Bus contract: every cycle is a complete request. MemRead/MemWrite qualify
  // Address in that cycle; there is no backpressure, loads answer
  // combinationally and stores commit at the closing rising edge.

  logic [7:0]         sync2;
  logic               chg;
  ioReg_e             regSel;
  logic               storeHit;
  logic               loadHit;
  logic               portOutWr;
  logic               clearWr;
  logic               portInRd;
  logic               changed;
  logic               changedNext;
  logic [COUNT_W-1:0] chgCount;
  logic [COUNT_W-1:0] chgCountNext;
  logic [31:0]        statusWord;
  logic [31:0]        readWord;

  port_in_sync uSync (
    .clk    (clk),
    .reset  (reset),
    .PortIn (PortIn),
    .sync2  (sync2),
    .chg    (chg)
  );

  assign IOSelect  = (Address[31:4] == IO_BASE[31:4]);
  assign regSel    = regOf(Address[3:0]);
  assign storeHit  = MemWrite & IOSelect;
  assign loadHit   = MemRead & IOSelect;
  assign portOutWr = storeHit && (regSel == regOf(PORT_OUT_OFS));
  assign clearWr   = storeHit && (regSel == regOf(CLEAR_OFS));
  assign portInRd  = loadHit && (regSel == regOf(PORT_IN_OFS));

  always_comb begin
    statusWord = '0;
    statusWord[ST_CHANGED] = changed;
    statusWord[ST_COUNT_LSB +: COUNT_W] = chgCount;
  end

  always_comb begin
    readWord = '0;
    if (loadHit) begin
      case (regSel)
        REG_PORT_OUT: readWord = PortOut;
        REG_PORT_IN:  readWord = {24'b0, sync2};
        REG_STATUS:   readWord = statusWord;
        default:      readWord = '0;
      endcase
    end
  end

  assign ReadData = DATA_WIDTH'(readWord);

  // Clears first, then a change event on the same edge wins over them.
  always_comb begin
    changedNext  = changed;
    chgCountNext = chgCount;
    if (clearWr) begin
      changedNext  = 1'b0;
      chgCountNext = '0;
    end else if (portInRd) begin
      changedNext = 1'b0;
    end
    if (chg) begin
      changedNext = 1'b1;
      if (chgCountNext != {COUNT_W{1'b1}}) chgCountNext = chgCountNext + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut       <= '0;
      PortOutStrobe <= 1'b0;
      changed       <= 1'b0;
      chgCount      <= '0;
    end else begin
      if (portOutWr) PortOut <= 32'(WriteData);
      PortOutStrobe <= portOutWr;
      changed       <= changedNext;
      chgCount      <= chgCountNext;
    end
  end

endmodule
